// File: rtl/geig_stack_serializer.sv
// Geiger word capture FIFO and byte-frame serializer (HDR, D0..D5[, CSUM]) on a valid/ready stream.
// Optional trailing XOR checksum byte is enabled by defining GEIG_CHECKSUM_EN.
module geig_stack_serializer #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [7:0]  HEADER_BYTE = 8'h47
) (
  input  logic        CLK_1KHZ,
  input  logic        RESET,
  input  logic        CLK_10HZ,
  input  logic [47:0] G_DATA_STACK,
  input  logic        BYTE_READY,
  output logic [7:0]  BYTE_OUT,
  output logic        BYTE_VALID,
  output logic [4:0]  FIFO_COUNT,
  output logic [7:0]  DROP_COUNT,
  output logic        BUSY
);

  localparam int         PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
`ifdef GEIG_CHECKSUM_EN
    , CSUM = 2'd3
`endif
  } state_e;

  logic             s1_q, s2_q, s3_q;
  logic [47:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]       count_q, count_d;
  logic [7:0]       drop_q, drop_d;
  state_e           state_q;
  logic [47:0]      shreg_q;
  logic [2:0]       idx_q;
  logic [7:0]       byte_q;
  logic             valid_q;
`ifdef GEIG_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  logic strobe, pop, full, push_ok;

  // One-cycle pulse on the synchronised rising edge of the frame tick.
  assign strobe  = s2_q & ~s3_q;
  assign full    = (count_q == DEPTH_C);
  assign pop     = (state_q == IDLE) && (count_q != 5'd0);
  // A pop on the same edge frees a slot, so a full FIFO still accepts the word.
  assign push_ok = strobe && (!full || pop);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    drop_d  = drop_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    if (strobe && !push_ok && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge CLK_1KHZ) begin
    if (push_ok) mem_q[wr_ptr_q] <= G_DATA_STACK;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge CLK_1KHZ) begin
    if (RESET) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
      drop_q   <= 8'd0;
      state_q  <= IDLE;
      shreg_q  <= 48'd0;
      idx_q    <= 3'd0;
      byte_q   <= 8'd0;
      valid_q  <= 1'b0;
`ifdef GEIG_CHECKSUM_EN
      csum_q   <= 8'd0;
`endif
    end else begin
      s1_q    <= CLK_10HZ;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      count_q <= count_d;
      drop_q  <= drop_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      case (state_q)
        IDLE: begin
          if (pop) begin
            shreg_q <= mem_q[rd_ptr_q];
            byte_q  <= HEADER_BYTE;
            valid_q <= 1'b1;
            state_q <= HDR;
          end
        end
        HDR: begin
          if (BYTE_READY) begin
            byte_q  <= shreg_q[47:40];
            shreg_q <= {shreg_q[39:0], 8'h00};
            idx_q   <= 3'd0;
            state_q <= DATA;
`ifdef GEIG_CHECKSUM_EN
            csum_q  <= shreg_q[47:40];
`endif
          end
        end
        DATA: begin
          if (BYTE_READY) begin
            if (idx_q == 3'd5) begin
`ifdef GEIG_CHECKSUM_EN
              byte_q  <= csum_q;
              state_q <= CSUM;
`else
              valid_q <= 1'b0;
              state_q <= IDLE;
`endif
            end else begin
              byte_q  <= shreg_q[47:40];
              shreg_q <= {shreg_q[39:0], 8'h00};
              idx_q   <= idx_q + 3'd1;
`ifdef GEIG_CHECKSUM_EN
              csum_q  <= csum_q ^ shreg_q[47:40];
`endif
            end
          end
        end
`ifdef GEIG_CHECKSUM_EN
        CSUM: begin
          if (BYTE_READY) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BYTE_OUT   = byte_q;
  assign BYTE_VALID = valid_q;
  assign FIFO_COUNT = count_q;
  assign DROP_COUNT = drop_q;
  assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_geig_stack_serializer.sv
// Self-checking bench for geig_stack_serializer: byte-stream scoreboard plus queue model of FIFO/drops.
module tb_geig_stack_serializer;

  localparam int DEPTH = 4;
`ifdef GEIG_CHECKSUM_EN
  localparam int FRAME_LEN = 8;
`else
  localparam int FRAME_LEN = 7;
`endif

  logic        clk_1khz   = 1'b0;
  logic        reset      = 1'b1;
  logic        clk_10hz   = 1'b0;
  logic [47:0] g_data     = 48'd0;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [4:0]  fifo_count;
  logic [7:0]  drop_count;
  logic        busy;

  geig_stack_serializer #(.FIFO_DEPTH(DEPTH), .HEADER_BYTE(8'h47)) dut (
    .CLK_1KHZ    (clk_1khz),
    .RESET       (reset),
    .CLK_10HZ    (clk_10hz),
    .G_DATA_STACK(g_data),
    .BYTE_READY  (byte_ready),
    .BYTE_OUT    (byte_out),
    .BYTE_VALID  (byte_valid),
    .FIFO_COUNT  (fifo_count),
    .DROP_COUNT  (drop_count),
    .BUSY        (busy)
  );

  always #5 clk_1khz = ~clk_1khz;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [47:0] pend_q[$];
  bit          sh_busy = 1'b0;
  int          model_drop = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_1khz);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  function automatic void expect_frame(input logic [47:0] w);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    exp_q.push_back(8'h47);
    for (int i = 0; i < 6; i++) begin
      b = w[47-8*i -: 8];
      exp_q.push_back(b);
      cs = cs ^ b;
    end
`ifdef GEIG_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endfunction

  // Word arriving while the downstream is stalled: first fills the frame slot, then the FIFO, then drops.
  function automatic void model_stalled_tick(input logic [47:0] w);
    if (!sh_busy) begin
      sh_busy = 1'b1;
      expect_frame(w);
    end else if (pend_q.size() < DEPTH) begin
      pend_q.push_back(w);
      expect_frame(w);
    end else if (model_drop < 255) begin
      model_drop++;
    end
  endfunction

  task automatic tick(input logic [47:0] w);
    g_data   = w;
    clk_10hz = 1'b1;
    cycles(3);
    clk_10hz = 1'b0;
    cycles(2);
  endtask

  task automatic drain(input string tag);
    byte_ready = 1'b1;
    for (int k = 0; k < 400 && (busy || fifo_count != 5'd0); k++) cyc();
    cyc();
    check({tag, "_busy"}, busy, 0);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_left"}, exp_q.size(), 0);
    sh_busy = 1'b0;
    pend_q.delete();
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom()), 32'($urandom())};
  endfunction

  // Scoreboard: every accepted byte must be the next byte of the expected stream.
  always @(negedge clk_1khz) begin
    if (!reset && byte_valid && byte_ready) begin
      if (exp_q.size() == 0) check("stream_extra", exp_q.size(), 1);
      else                   check("stream_byte", byte_out, exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] w, wa, wb, wc;

    // Reset with the tick toggling: nothing may be captured.
    for (int i = 0; i < 3; i++) begin
      cyc();
      clk_10hz = ~clk_10hz;
    end
    clk_10hz = 1'b0;
    check("rst_byte", byte_out, 0);
    check("rst_valid", byte_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    cycles(4);
    check("post_rst_count", fifo_count, 0);
    check("post_rst_valid", byte_valid, 0);

    // Single word, downstream always ready, cycle-exact latency.
    byte_ready = 1'b1;
    wa = 48'h0123_4567_89AB;
    expect_frame(wa);
    g_data   = wa;
    clk_10hz = 1'b1;
    cycles(3);
    check("one_capture_count", fifo_count, 1);
    check("one_capture_valid", byte_valid, 0);
    cyc();
    check("one_first_valid", byte_valid, 1);
    check("one_first_byte", byte_out, 8'h47);
    check("one_popped_count", fifo_count, 0);
    check("one_busy", busy, 1);
    clk_10hz = 1'b0;
    drain("one");

    // Backpressure while D2 is presented.
    expect_frame(wa);
    tick(wa);
    for (int k = 0; k < 20 && !(byte_valid && byte_out == 8'h45); k++) cyc();
    check("bp_reach", byte_out, 8'h45);
    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_hold_byte", byte_out, 8'h45);
      check("bp_hold_valid", byte_valid, 1);
    end
    drain("bp");

    // Fill while stalled, then land a capture on the very edge that pops a full FIFO.
    byte_ready = 1'b0;
    for (int i = 0; i < 1 + DEPTH; i++) begin
      w = rnd48();
      model_stalled_tick(w);
      tick(w);
    end
    check("full_count", fifo_count, pend_q.size());
    check("full_drop", drop_count, model_drop);
    check("full_busy", busy, 1);
    check("full_hdr", byte_out, 8'h47);
    byte_ready = 1'b1;
    cycles(FRAME_LEN - 2);
    w = rnd48();
    g_data   = w;
    clk_10hz = 1'b1;
    cycles(3);
    void'(pend_q.pop_front());
    pend_q.push_back(w);
    expect_frame(w);
    check("popfull_count", fifo_count, pend_q.size());
    check("popfull_drop", drop_count, model_drop);
    clk_10hz = 1'b0;
    drain("popfull");

    // Overflow while stalled, then saturation of the drop counter.
    byte_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w = rnd48();
      model_stalled_tick(w);
      tick(w);
    end
    check("ovf_count", fifo_count, pend_q.size());
    check("ovf_drop", drop_count, model_drop);
    for (int i = 0; i < 260; i++) begin
      w = rnd48();
      model_stalled_tick(w);
      tick(w);
    end
    check("sat_drop", drop_count, model_drop);
    check("sat_count", fifo_count, pend_q.size());
    drain("ovf");
    check("sat_drop_kept", drop_count, model_drop);

    // Reset mid-frame with a word waiting in the FIFO.
    byte_ready = 1'b0;
    wb = rnd48();
    expect_frame(wa);
    expect_frame(wb);
    tick(wa);
    tick(wb);
    check("abort_pre_count", fifo_count, 1);
    byte_ready = 1'b1;
    for (int k = 0; k < 20 && !(byte_valid && byte_out == 8'h45); k++) cyc();
    check("abort_at_d2", byte_out, 8'h45);
    reset = 1'b1;
    exp_q.delete();
    cyc();
    check("abort_valid", byte_valid, 0);
    check("abort_count", fifo_count, 0);
    check("abort_busy", busy, 0);
    check("abort_byte", byte_out, 0);
    check("abort_drop", drop_count, 0);
    cyc();
    reset = 1'b0;
    cyc();
    wc = rnd48();
    expect_frame(wc);
    g_data   = wc;
    clk_10hz = 1'b1;
    cycles(4);
    check("restart_valid", byte_valid, 1);
    check("restart_hdr", byte_out, 8'h47);
    clk_10hz = 1'b0;
    drain("restart");

    // Random words with random downstream readiness.
    for (int i = 0; i < 20; i++) begin
      w = rnd48();
      expect_frame(w);
      tick(w);
      for (int k = 0; k < 35; k++) begin
        byte_ready = ($urandom_range(3) != 0);
        cyc();
      end
    end
    drain("rand");
    check("rand_drop", drop_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
